ram_memory_game: RTL and testbench
==================================

# ram_memory_game

Downstream stage of the ROM password block: once `RAM_access` is granted, it runs the memory-tester game rounds.

- Each round generates a pseudo-random sequence of 4-bit symbols into an internal RAM and flashes them one by one on the display.
- The player then re-enters the symbols on the toggle switches.
- It reports pass/fail and keeps a saturating score until logout.

## Interface

Parameters:
- `SEQ_LEN`, 4: symbols per round, legal range 1–8.
- `SHOW_CYCLES`, 8: cycles each symbol is shown, and also the length of the blank gap after it; must be ≥1.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.
- `TIMEOUT_CYCLES`, 64: entry timeout. Used only with `GAME_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `RAM_access` in 1: level input from the password block; the game runs only while it is high.
- `rng_button` in 1: level input; its rising edge starts a round.
- `enter_button` in 1: level input; its rising edge submits `toggle_entry`.
- `log_out` in 1: level input; while high, the block returns to idle and clears the score.
- `toggle_entry` in 4: player's symbol.
- `display` out 4: symbol being shown; 0 when not showing.
- `display_valid` out 1: high while `display` holds a sequence symbol.
- `busy` out 1: high in GEN, SHOW, GAP and ENTER.
- `round_pass` out 1: last round passed; held.
- `round_fail` out 1: last round failed; held.
- `score` out 4: rounds passed since logout; saturates at 15.

## Operation

- **Edge detection.** Both buttons are registered every cycle. Edge = input & ~registered copy.
- **LFSR.** 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1). Shifts every cycle in every state and never reaches 0.
- **Storage.** 8×4 register RAM with an index counter `idx` of 3 bits.
- **FSM states:**
  - **IDLE:** all status outputs held.
    - `rng_button` edge while `RAM_access`=1 → GEN. On entry to GEN: `idx`=0, `round_pass`=`round_fail`=0.
  - **GEN:** writes LFSR[3:0] to mem[`idx`] each cycle, `idx`++.
    - After writing `SEQ_LEN` entries → SHOW with `idx`=0.
  - **SHOW:** `display`=mem[`idx`], `display_valid`=1 for `SHOW_CYCLES` cycles → GAP.
  - **GAP:** `display`=0, `display_valid`=0 for `SHOW_CYCLES` cycles.
    - Then `idx`++ and → SHOW.
    - After the last symbol: `idx`=0 and → ENTER.
  - **ENTER:** on each `enter_button` edge, compare `toggle_entry` with mem[`idx`].
    - Mismatch → FAIL.
    - Match on the last index → PASS.
    - Any other match → `idx`++.
  - **PASS:** for one cycle, `round_pass`=1 and `score`=min(`score`+1, 15) → IDLE.
  - **FAIL:** for one cycle, `round_fail`=1 → IDLE.
- **Abort priority, highest first:**
  1. `log_out`=1 → IDLE; clears `score`, `round_pass`, `round_fail`.
  2. `RAM_access`=0 → IDLE; `score` kept, `round_pass`/`round_fail` cleared.
  3. Normal FSM transitions.
- **Ignored inputs:**
  - `rng_button` edges outside IDLE.
  - `enter_button` edges outside ENTER.
  - An `enter_button` edge in the same cycle as `rng_button` in IDLE.

## Timing

- **Reset (`rst`=0 at a clock edge):**
  - State IDLE.
  - `display`=0, `display_valid`=0, `busy`=0, `round_pass`=0, `round_fail`=0, `score`=0.
  - LFSR=`LFSR_SEED`, button registers=0.
  - Reset mid-round behaves the same; RAM contents need not clear.
- **Outputs:** all registered.
  - An input sampled at edge *n* produces an output change visible after edge *n*.
- **Round start:** the `rng_button` edge sampled at edge *n* puts the FSM in GEN from edge *n*.
  - First `display_valid`=1 after edge *n*+`SEQ_LEN`.
- **Show phase:** lasts exactly 2·`SHOW_CYCLES`·`SEQ_LEN` cycles.
- **Entry result:** the final matching entry sampled at edge *m* gives `round_pass`=1 and the incremented `score` after edge *m*+1.
- **Held button:** counts once; a new press requires a low sample first.

## Configuration

- **`GAME_TIMEOUT_EN` defined:**
  - ENTER runs a counter, cleared on entry to ENTER and on every accepted `enter_button` edge.
  - Reaching `TIMEOUT_CYCLES` without an edge → FAIL.
  - If an edge and expiry fall in the same cycle, the entry is evaluated and the timeout is ignored.
- **Not defined:** no counter; ENTER waits indefinitely.

## Test plan

1. **Reset:** hold `rst`=0 for 2 cycles, then release. → All outputs 0, `busy`=0; LFSR = 8'hA5 at the first edge after release.
2. **Correct round:** `RAM_access`=1, pulse `rng_button`.
   - Bench model mirrors the LFSR from reset and predicts the 4 symbols.
   - Check each symbol shows for 8 cycles with 8 blank cycles between.
   - Enter all 4 correctly. → `round_pass`=1, `score`=1, `busy`=0.
3. **Wrong entry:** on the 2nd entry submit the predicted value XOR 4'h1. → `round_fail`=1 on the next cycle; `score` unchanged.
4. **Abort:**
   - `RAM_access` dropped during SHOW → IDLE, `display_valid`=0, `score` kept.
   - `log_out` pulse → `score`=0.
5. **Saturation and held button:**
   - 16 passing rounds → `score` stays 15.
   - `rng_button` held high for 20 cycles starts only one round.
6. **Timeout (`GAME_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64):** no entry. → `round_fail`=1 after 64 cycles in ENTER.
   - Without the macro: still in ENTER with `busy`=1 after 200 cycles.

Source files
------------

// File: rtl/ram_memory_game.sv
// ram_memory_game: memory-tester game run after the password block grants
// RAM_access. Each round fills an 8x4 register RAM from an 8-bit LFSR,
// flashes the symbols on the display, then checks the player's entries and
// keeps a saturating score until logout.
// Optional build macro: GAME_TIMEOUT_EN adds an entry timeout of
// TIMEOUT_CYCLES cycles in the ENTER phase; without it ENTER waits forever.
//
// Display qualifier: display_valid is high exactly while display carries a
// sequence symbol; display is forced to 0 whenever display_valid is low.
// There is no back-pressure, so the viewer must sample every shown cycle.

module ram_memory_game #(
  parameter int         SEQ_LEN        = 4,
  parameter int         SHOW_CYCLES    = 8,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       RAM_access,
  input  logic       rng_button,
  input  logic       enter_button,
  input  logic       log_out,
  input  logic [3:0] toggle_entry,
  output logic [3:0] display,
  output logic       display_valid,
  output logic       busy,
  output logic       round_pass,
  output logic       round_fail,
  output logic [3:0] score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW,
    S_GAP,
    S_ENTER,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);
  localparam int CW = $clog2(SHOW_CYCLES + 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);

  state_t        state;
  logic [7:0]    lfsr;
  logic          rng_q;
  logic          enter_q;
  logic          rng_edge;
  logic          enter_edge;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [3:0]    mem [0:7];

`ifdef GAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  assign rng_edge   = rng_button & ~rng_q;
  assign enter_edge = enter_button & ~enter_q;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1; the seed is non-zero so it never locks up
  always_ff @(posedge clock) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Previous-cycle copies of the buttons for rising-edge detection
  always_ff @(posedge clock) begin
    if (!rst) begin
      rng_q   <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      rng_q   <= rng_button;
      enter_q <= enter_button;
    end
  end

  // Symbol RAM: filled one entry per cycle while generating; contents survive reset
  always_ff @(posedge clock) begin
    if (rst && (state == S_GEN)) mem[idx] <= lfsr[3:0];
  end

  // Game FSM with registered outputs; logout beats access loss beats normal flow
  always_ff @(posedge clock) begin
    if (!rst) begin
      state         <= S_IDLE;
      idx           <= 3'd0;
      cnt           <= '0;
      display       <= 4'd0;
      display_valid <= 1'b0;
      busy          <= 1'b0;
      round_pass    <= 1'b0;
      round_fail    <= 1'b0;
      score         <= 4'd0;
`ifdef GAME_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else if (log_out || !RAM_access) begin
      state         <= S_IDLE;
      idx           <= 3'd0;
      cnt           <= '0;
      display       <= 4'd0;
      display_valid <= 1'b0;
      busy          <= 1'b0;
      round_pass    <= 1'b0;
      round_fail    <= 1'b0;
      if (log_out) score <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rng_edge) begin
            state      <= S_GEN;
            idx        <= 3'd0;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_GEN: begin
          if (idx == LAST_IDX) begin
            // First symbol goes out on the same edge as the last write;
            // with a one-symbol sequence it is the value being written now.
            state         <= S_SHOW;
            idx           <= 3'd0;
            cnt           <= '0;
            display       <= (idx == 3'd0) ? lfsr[3:0] : mem[0];
            display_valid <= 1'b1;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state         <= S_GAP;
            cnt           <= '0;
            display       <= 4'd0;
            display_valid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == SHOW_LAST) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state <= S_ENTER;
              idx   <= 3'd0;
`ifdef GAME_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              state         <= S_SHOW;
              idx           <= idx + 3'd1;
              display       <= mem[idx + 3'd1];
              display_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ENTER: begin
          if (enter_edge) begin
`ifdef GAME_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (toggle_entry != mem[idx]) begin
              state <= S_FAIL;
              busy  <= 1'b0;
            end else if (idx == LAST_IDX) begin
              state <= S_PASS;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
`ifdef GAME_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state <= S_FAIL;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_PASS: begin
          round_pass <= 1'b1;
          score      <= (score == 4'd15) ? 4'd15 : score + 4'd1;
          state      <= S_IDLE;
        end
        S_FAIL: begin
          round_fail <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_memory_game.sv
// Testbench for ram_memory_game: scenario tasks with inline comparisons and a
// queue of predicted display symbols filled while a round is generated.
module tb_ram_memory_game;

  localparam int         SEQ_LEN     = 4;
  localparam int         SHOW_CYCLES = 8;
  localparam logic [7:0] SEED        = 8'hA5;

  logic       clock = 1'b0;
  logic       rst;
  logic       RAM_access;
  logic       rng_button;
  logic       enter_button;
  logic       log_out;
  logic [3:0] toggle_entry;
  logic [3:0] display;
  logic       display_valid;
  logic       busy;
  logic       round_pass;
  logic       round_fail;
  logic [3:0] score;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_score = 0;

  logic [3:0] exp_q [$];
  logic [3:0] sym [0:7];
  logic [7:0] m_lfsr;

  ram_memory_game dut (
    .clock        (clock),
    .rst          (rst),
    .RAM_access   (RAM_access),
    .rng_button   (rng_button),
    .enter_button (enter_button),
    .log_out      (log_out),
    .toggle_entry (toggle_entry),
    .display      (display),
    .display_valid(display_valid),
    .busy         (busy),
    .round_pass   (round_pass),
    .round_fail   (round_fail),
    .score        (score)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // reference LFSR built from the polynomial tap list x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int taps [4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i] - 1];
    return {s[6:0], fb};
  endfunction

  always @(posedge clock) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= lfsr_next(m_lfsr);
  end

  // ---------------- driver tasks ----------------
  // Pulse (or hold) rng_button and record the symbols the round will use.
  task automatic start_round(input bit hold);
    @(negedge clock);
    rng_button = 1'b1;
    @(negedge clock);
    if (!hold) rng_button = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_gen: got %b expected 1", busy);
    else pass_cnt++;
    total_cnt++;
    if ({round_pass, round_fail} !== 2'b00)
      $display("FAIL status_clear_on_start: got %b expected 00", {round_pass, round_fail});
    else pass_cnt++;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (k > 0) @(negedge clock);
      sym[k] = m_lfsr[3:0];
      exp_q.push_back(sym[k]);
    end
    total_cnt++;
    if (display_valid !== 1'b0)
      $display("FAIL show_latency: got display_valid=%b expected 0", display_valid);
    else pass_cnt++;
  endtask

  // Walk the whole show phase; pops one predicted symbol per show window.
  task automatic show_phase(input bit chk);
    logic [3:0] cur = 4'd0;
    logic       ev;
    logic [3:0] ed;
    for (int c = 0; c < 2 * SHOW_CYCLES * SEQ_LEN; c++) begin
      @(negedge clock);
      if ((c % (2 * SHOW_CYCLES)) == 0) cur = exp_q.pop_front();
      ev = ((c % (2 * SHOW_CYCLES)) < SHOW_CYCLES);
      ed = ev ? cur : 4'd0;
      if (chk) begin
        total_cnt++;
        if ({display_valid, display} !== {ev, ed})
          $display("FAIL show_cycle_%0d: got valid=%b disp=%h expected valid=%b disp=%h",
                   c, display_valid, display, ev, ed);
        else pass_cnt++;
      end
    end
    @(negedge clock);
    if (chk) begin
      total_cnt++;
      if ({busy, display_valid} !== 2'b10)
        $display("FAIL enter_phase: got busy=%b valid=%b expected busy=1 valid=0",
                 busy, display_valid);
      else pass_cnt++;
    end
  endtask

  task automatic press_entry(input logic [3:0] v);
    @(negedge clock);
    toggle_entry = v;
    enter_button = 1'b1;
    @(negedge clock);
    enter_button = 1'b0;
  endtask

  // Enter every symbol correctly and check the pass result one cycle later.
  task automatic enter_all_and_check_pass(input string tag);
    for (int k = 0; k < SEQ_LEN; k++) press_entry(sym[k]);
    @(negedge clock);
    exp_score = (exp_score >= 15) ? 15 : exp_score + 1;
    total_cnt++;
    if ({round_pass, round_fail, busy} !== 3'b100)
      $display("FAIL %s_result: got pass=%b fail=%b busy=%b expected pass=1 fail=0 busy=0",
               tag, round_pass, round_fail, busy);
    else pass_cnt++;
    total_cnt++;
    if (score !== 4'(exp_score))
      $display("FAIL %s_score: got %0d expected %0d", tag, score, exp_score);
    else pass_cnt++;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b0; RAM_access = 1'b0; rng_button = 1'b0;
    enter_button = 1'b0; log_out = 1'b0; toggle_entry = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total_cnt++;
    if ({display, display_valid} !== 5'd0)
      $display("FAIL reset_display: got %h/%b expected 0/0", display, display_valid);
    else pass_cnt++;
    total_cnt++;
    if ({busy, round_pass, round_fail} !== 3'b000)
      $display("FAIL reset_status: got %b expected 000", {busy, round_pass, round_fail});
    else pass_cnt++;
    total_cnt++;
    if (score !== 4'd0) $display("FAIL reset_score: got %0d expected 0", score);
    else pass_cnt++;
    rst = 1'b1;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({busy, display_valid, score} !== 6'd0)
      $display("FAIL post_reset_idle: got busy=%b valid=%b score=%0d expected 0", busy,
               display_valid, score);
    else pass_cnt++;
  endtask

  task automatic test_correct_round();
    RAM_access = 1'b1;
    start_round(1'b0);
    show_phase(1'b1);
    enter_all_and_check_pass("correct");
  endtask

  task automatic test_wrong_entry();
    start_round(1'b0);
    show_phase(1'b1);
    press_entry(sym[0]);
    press_entry(sym[1] ^ 4'h1);
    total_cnt++;
    if (round_fail !== 1'b0) $display("FAIL fail_early: got %b expected 0", round_fail);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if ({round_fail, round_pass, busy} !== 3'b100)
      $display("FAIL wrong_result: got fail=%b pass=%b busy=%b expected 1 0 0",
               round_fail, round_pass, busy);
    else pass_cnt++;
    total_cnt++;
    if (score !== 4'(exp_score)) $display("FAIL wrong_score: got %0d expected %0d", score, exp_score);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    start_round(1'b0);
    repeat (3) @(negedge clock);
    total_cnt++;
    if (display_valid !== 1'b1) $display("FAIL abort_pre_show: got %b expected 1", display_valid);
    else pass_cnt++;
    RAM_access = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({display_valid, display, busy} !== 6'd0)
      $display("FAIL abort_idle: got valid=%b disp=%h busy=%b expected 0", display_valid,
               display, busy);
    else pass_cnt++;
    total_cnt++;
    if (score !== 4'(exp_score)) $display("FAIL abort_score: got %0d expected %0d", score, exp_score);
    else pass_cnt++;
    exp_q.delete();
    RAM_access = 1'b1;
    repeat (5) @(negedge clock);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_no_resume: got %b expected 0", busy);
    else pass_cnt++;
    log_out = 1'b1;
    @(negedge clock);
    log_out = 1'b0;
    exp_score = 0;
    total_cnt++;
    if (score !== 4'd0) $display("FAIL logout_score: got %0d expected 0", score);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 16; r++) begin
      start_round(1'b0);
      show_phase(1'b0);
      enter_all_and_check_pass("sat");
    end
    total_cnt++;
    if (score !== 4'd15) $display("FAIL sat_final: got %0d expected 15", score);
    else pass_cnt++;
  endtask

  task automatic test_held_button();
    start_round(1'b1);
    show_phase(1'b1);
    enter_all_and_check_pass("held");
    repeat (20) @(negedge clock);
    total_cnt++;
    if ({busy, display_valid} !== 2'b00)
      $display("FAIL held_single_round: got busy=%b valid=%b expected 00", busy, display_valid);
    else pass_cnt++;
    rng_button = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    start_round(1'b0);
    show_phase(1'b0);
`ifdef GAME_TIMEOUT_EN
    begin
      int k = 0;
      while (round_fail !== 1'b1 && k < 100) begin
        @(negedge clock);
        k++;
      end
      total_cnt++;
      if (round_fail !== 1'b1 || k < 64 || k > 66)
        $display("FAIL timeout_fail: got fail=%b after %0d cycles expected 1 after 64..66",
                 round_fail, k);
      else pass_cnt++;
    end
`else
    repeat (200) @(negedge clock);
    total_cnt++;
    if ({busy, round_fail} !== 2'b10)
      $display("FAIL no_timeout_wait: got busy=%b fail=%b expected 1 0", busy, round_fail);
    else pass_cnt++;
`endif
    log_out = 1'b1;
    @(negedge clock);
    log_out = 1'b0;
    exp_score = 0;
    total_cnt++;
    if ({busy, score} !== 5'd0)
      $display("FAIL timeout_logout: got busy=%b score=%0d expected 0", busy, score);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_correct_round();
    test_wrong_entry();
    test_abort();
    test_saturation();
    test_held_button();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
